// File: rtl/rca_seq_pkg.sv
// rtl/rca_seq_pkg.sv - shared types, constants and width check for the sequential nibble adder
package rca_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int SLICE_W = 4;

    // A legal width is a whole number of slices, at least one slice wide
    function automatic bit width_ok(input int w);
        return (w >= SLICE_W) && ((w % SLICE_W) == 0);
    endfunction

endpackage

// File: rtl/nibble_add4.sv
// rtl/nibble_add4.sv - 4-bit ripple-carry adder slice exposing the carry into its top bit
module nibble_add4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       ci,
    output logic [3:0] s,
    output logic       co,
    output logic       c3
);

    logic [4:0] c;

    // Ripple chain: c[i] is the carry into bit i
    always_comb begin
        c    = '0;
        s    = '0;
        c[0] = ci;
        for (int i = 0; i < 4; i++) begin
            s[i]     = a[i] ^ b[i] ^ c[i];
            c[i + 1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
        end
    end

    assign co = c[4];
    assign c3 = c[3];

endmodule

// File: rtl/rca_seq_add_ctrl.sv
// rtl/rca_seq_add_ctrl.sv - wide adder time-multiplexed over one nibble slice; optional subtract via RCA_SUB_EN
module rca_seq_add_ctrl
    import rca_seq_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef RCA_SUB_EN
    input  logic             op_sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int N     = WIDTH / SLICE_W;
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

    if (!width_ok(WIDTH)) begin : g_bad_width
        $error("rca_seq_add_ctrl: WIDTH must be a multiple of 4 and at least 4");
    end

    state_t             state;
    state_t             state_nx;
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   b_q;
    logic [WIDTH-1:0]   sum_q;
    logic               carry_q;
    logic [IDX_W-1:0]   idx;
    logic               cout_q;
    logic               ovf_q;

    logic [SLICE_W-1:0] sl_a;
    logic [SLICE_W-1:0] sl_b;
    logic [SLICE_W-1:0] sl_s;
    logic               sl_co;
    logic               sl_c3;
    logic               last_slice;
    logic               b_inv;
    logic               carry_init;

    assign sl_a       = a_q[idx*SLICE_W +: SLICE_W];
    assign sl_b       = b_q[idx*SLICE_W +: SLICE_W];
    assign last_slice = (idx == LAST_IDX);

`ifdef RCA_SUB_EN
    // Subtraction is a + ~b + 1; cin is overridden by the forced carry
    assign b_inv      = op_sub;
    assign carry_init = op_sub ? 1'b1 : cin;
`else
    assign b_inv      = 1'b0;
    assign carry_init = cin;
`endif

    nibble_add4 u_slice (
        .a  (sl_a),
        .b  (sl_b),
        .ci (carry_q),
        .s  (sl_s),
        .co (sl_co),
        .c3 (sl_c3)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state: accept in IDLE, walk the slices in RUN, hold in DONE until taken
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (in_valid)   state_nx = RUN;
            RUN:     if (last_slice) state_nx = DONE;
            DONE:    if (out_ready)  state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Datapath: latch operands on accept, then one nibble of sum per RUN cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            idx     <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_q     <= a;
                        b_q     <= b_inv ? ~b : b;
                        carry_q <= carry_init;
                        idx     <= '0;
                    end
                end
                RUN: begin
                    sum_q[idx*SLICE_W +: SLICE_W] <= sl_s;
                    carry_q                       <= sl_co;
                    if (last_slice) begin
                        cout_q <= sl_co;
                        ovf_q  <= sl_c3 ^ sl_co;
                        idx    <= '0;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Handshake flags are pure decodes of the state register
    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_rca_seq_add_ctrl.sv
// tb/tb_rca_seq_add_ctrl.sv - self-checking bench for rca_seq_add_ctrl at WIDTH=16
module tb_rca_seq_add_ctrl;

    localparam int W = 16;
    localparam int N = W / 4;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic         sub;
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
    } vec_t;

    typedef struct {
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         cin = 1'b0;
    logic         op_sub = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;

    int checks = 0;
    int errors = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    rca_seq_add_ctrl #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
`ifdef RCA_SUB_EN
        .op_sub    (op_sub),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    function automatic exp_t model(input logic [W-1:0] va, input logic [W-1:0] vb, input logic vc);
        exp_t e;
        logic [W:0] full;
        full   = {1'b0, va} + {1'b0, vb} + {{W{1'b0}}, vc};
        e.sum  = full[W-1:0];
        e.cout = full[W];
        e.ovf  = (va[W-1] == vb[W-1]) && (e.sum[W-1] != va[W-1]);
        return e;
    endfunction

    // Drive one operand set at a negedge and return after its acceptance edge
    task automatic drive(input vec_t v, input string tag);
        int w;
        exp_t e;
        w = 0;
        while (!in_ready && w < 20) begin
            @(negedge clk);
            w++;
        end
        check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        a        = v.a;
        b        = v.b;
        cin      = v.cin;
        op_sub   = v.sub;
        e.sum    = v.sum;
        e.cout   = v.cout;
        e.ovf    = v.ovf;
        sb.push_back(e);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        op_sub   = 1'b0;
    endtask

    // Count edges after acceptance until out_valid, then compare against the scoreboard
    task automatic wait_and_compare(input string tag);
        int lat;
        exp_t e;
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        check({tag, "_latency"}, 32'(lat), 32'(N));
        if (sb.size() == 0) begin
            check({tag, "_sb_nonempty"}, 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            check({tag, "_sum"}, 32'(sum), 32'(e.sum));
            check({tag, "_cout"}, 32'(cout), 32'(e.cout));
            check({tag, "_ovf"}, 32'(ovf), 32'(e.ovf));
        end
    endtask

    task automatic handshake(input string tag);
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        check({tag, "_ov_fall"}, 32'(out_valid), 32'd0);
        check({tag, "_ir_rise"}, 32'(in_ready), 32'd1);
    endtask

    task automatic run_op(input vec_t v, input string tag);
        drive(v, tag);
        wait_and_compare(tag);
        handshake(tag);
    endtask

    vec_t   tbl[$];
    vec_t   v;
    exp_t   e;
    exp_t   held;

    initial begin
        tbl.push_back('{16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0});
        tbl.push_back('{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0});
        tbl.push_back('{16'h7FFF, 16'h0000, 1'b1, 1'b0, 16'h8000, 1'b0, 1'b1});
        tbl.push_back('{16'h0F0F, 16'h00F1, 1'b0, 1'b0, 16'h1000, 1'b0, 1'b0});
        tbl.push_back('{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1});
        tbl.push_back('{16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1, 1'b0});
        tbl.push_back('{16'h4000, 16'h4000, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1});
`ifdef RCA_SUB_EN
        tbl.push_back('{16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0});
        tbl.push_back('{16'h8000, 16'h0001, 1'b1, 1'b1, 16'h7FFF, 1'b1, 1'b1});
`endif

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_sum", 32'(sum), 32'd0);
        check("rst_cout", 32'(cout), 32'd0);
        check("rst_ovf", 32'(ovf), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Table-driven vectors
        foreach (tbl[i]) begin
            run_op(tbl[i], $sformatf("vec%0d", i));
        end

        // Random additions against the reference model
        for (int i = 0; i < 6; i++) begin
            v.a   = W'($urandom);
            v.b   = W'($urandom);
            v.cin = 1'($urandom);
            v.sub = 1'b0;
            e     = model(v.a, v.b, v.cin);
            v.sum = e.sum; v.cout = e.cout; v.ovf = e.ovf;
            run_op(v, $sformatf("rnd%0d", i));
        end

        // Backpressure: result held while in_valid toggles with new operands
        v = '{16'h1111, 16'h2222, 1'b1, 1'b0, 16'h3334, 1'b0, 1'b0};
        drive(v, "bp");
        wait_and_compare("bp");
        held.sum = v.sum; held.cout = v.cout; held.ovf = v.ovf;
        for (int i = 0; i < 5; i++) begin
            in_valid = ~in_valid;
            a        = 16'hA5A5 ^ W'(i);
            b        = 16'h5A5A;
            @(posedge clk);
            @(negedge clk);
            check($sformatf("bp_sum_c%0d", i), 32'(sum), 32'(held.sum));
            check($sformatf("bp_cout_c%0d", i), 32'(cout), 32'(held.cout));
            check($sformatf("bp_ovf_c%0d", i), 32'(ovf), 32'(held.ovf));
            check($sformatf("bp_in_ready_c%0d", i), 32'(in_ready), 32'd0);
            check($sformatf("bp_out_valid_c%0d", i), 32'(out_valid), 32'd1);
        end
        in_valid = 1'b0;
        handshake("bp");
        repeat (N + 2) @(negedge clk);
        check("bp_no_ghost_op", 32'(out_valid), 32'd0);
        check("bp_still_idle", 32'(in_ready), 32'd1);
        run_op('{16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0}, "bp_next");

        // Reset mid-RUN
        v = '{16'h0FFF, 16'h0FFF, 1'b0, 1'b0, 16'h1FFE, 1'b0, 1'b0};
        in_valid = 1'b1; a = v.a; b = v.b; cin = v.cin;
        e.sum = v.sum; e.cout = v.cout; e.ovf = v.ovf;
        sb.push_back(e);
        @(posedge clk);
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        void'(sb.pop_back());
        #1;
        check("mrst_in_ready", 32'(in_ready), 32'd1);
        check("mrst_out_valid", 32'(out_valid), 32'd0);
        check("mrst_sum", 32'(sum), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < N + 3; i++) begin
            @(negedge clk);
            check($sformatf("mrst_no_stale_c%0d", i), 32'(out_valid), 32'd0);
        end
        run_op('{16'h0001, 16'h0001, 1'b0, 1'b0, 16'h0002, 1'b0, 1'b0}, "mrst_next");

        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Global watchdog so the run can never hang
    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/rca_seq_add_ctrl.md
# rca_seq_add_ctrl

Multi-cycle wide-operand adder controller. It time-multiplexes a single 4-bit ripple-carry slice across a WIDTH-bit addition, one nibble per cycle, LSB first, registering the inter-nibble carry. It sits between an operand producer and a result consumer, with valid/ready handshakes on both sides. It trades latency for area against a full-width ripple chain.

## Interface
Parameters:
- WIDTH, 16, operand/result width; must be a multiple of 4 and at least 4.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  reset, asynchronous and active-low.
- in_valid  in  1  operands valid.
- in_ready  out  1  block can accept operands.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- cin  in  1  carry-in to bit 0.
- op_sub  in  1  subtract select; present only with RCA_SUB_EN.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- sum  out  WIDTH  result.
- cout  out  1  carry out of MSB.
- ovf  out  1  signed overflow.

## Operation
- N = WIDTH/4 slices. Internal registers:
  - a_q, b_q: latched operands.
  - sum_q
  - carry_q: 1 bit.
  - idx: ceil(log2(N)) bits, minimum 1.
  - state
- States:
  - IDLE: in_ready=1. On in_valid, latch a and b, set carry_q=cin, idx=0, and go to RUN.
  - RUN: in_ready=0.
    - Each cycle, feed a_q[4*idx+:4], b_q[4*idx+:4] and carry_q to the slice.
    - Write the slice sum into sum_q[4*idx+:4] and the slice carry-out into carry_q, then increment idx.
    - On the slice where idx==N-1: cout ← slice carry-out; ovf ← slice c3 XOR slice carry-out, where c3 is the carry into bit WIDTH-1. Go to DONE.
  - DONE: out_valid=1. sum, cout and ovf hold stable. When out_ready=1, go to IDLE.
- Only one operation is in flight at a time. in_valid is ignored outside IDLE. No operand is ever dropped once accepted, except by reset.
- The carry-out of the final slice never wraps into bit 0.
- Reset values: state=IDLE, in_ready=1, out_valid=0, sum=0, cout=0, ovf=0, idx=0, carry_q=0.
- Reset asserted mid-RUN or mid-DONE aborts the operation. The result is discarded and never presented.

## Timing
- Acceptance edge E0 is the edge where in_valid & in_ready are both 1.
- RUN covers edges E0+1 … E0+N. out_valid rises at edge E0+N. For WIDTH=16, out_valid is high 4 cycles after acceptance.
- Handshake completes at edge Ed, where out_valid & out_ready are both 1:
  - out_valid falls at Ed; in_ready rises at Ed.
  - The next acceptance is possible at Ed+1 at the earliest.
- Peak throughput is one operation per N+2 cycles.
- in_ready and out_valid are registered; neither depends combinationally on inputs.
- out_ready held low keeps DONE indefinitely, with outputs frozen.

## Configuration
- RCA_SUB_EN
  - Defined: op_sub port exists and is sampled at acceptance.
    - op_sub=1: b_q ← ~b and carry_q ← 1, so the result is a − b.
    - cin is ignored when op_sub=1.
    - cout = 1 means no borrow. ovf is the signed overflow of the subtraction.
  - Undefined: port absent; the block is add-only.

## Structure
- Package rca_seq_pkg holds:
  - state enum {IDLE, RUN, DONE}
  - SLICE_W = 4
  - a WIDTH-legality check function
- Sub-module nibble_add4: 4-bit ripple adder slice.
  - Inputs: a[3:0], b[3:0], ci.
  - Outputs: s[3:0], co, c3 (carry into bit 3).
  - It is instantiated exactly once; the controller owns all sequencing.
- Elaboration fails on WIDTH%4≠0 or WIDTH<4.

## Test plan
All scenarios use WIDTH=16.
- a=0x1234, b=0x4321, cin=0 → sum=0x5555, cout=0, ovf=0; out_valid exactly 4 cycles after acceptance.
- a=0xFFFF, b=0x0001, cin=0 → sum=0x0000, cout=1, ovf=0. Checks carry propagation through all 4 slices.
- a=0x7FFF, b=0x0000, cin=1 → sum=0x8000, cout=0, ovf=1.
- Backpressure:
  - Stimulus: result ready, out_ready held low 5 cycles, in_valid toggled with new operands.
  - Required: sum, cout, ovf stable; in_ready=0; the new operands are not accepted.
  - On out_ready=1, in_ready=1 on the next cycle and the next operand is accepted normally.
- Reset mid-op:
  - Stimulus: rst_n pulsed low after 2 RUN cycles.
  - Required: immediately in_ready=1, out_valid=0, sum=0. No stale result appears after release. The next operation (0x0001+0x0001) yields 0x0002.
- With RCA_SUB_EN: op_sub=1, a=0x0005, b=0x0007 → sum=0xFFFE, cout=0, ovf=0; a=0x8000, b=0x0001 → sum=0x7FFF, cout=1, ovf=1.
